// File: rtl/csi_tx_packet_gen.sv
`default_nettype none
// ============================================================================
// csi_tx_packet_gen : CSI-2 TX packet builder (header+ECC, payload, CRC-16)
//                     framed by HS lead/trail and an LP gap.
// Revision 1.0
// ============================================================================
module csi_tx_packet_gen #(
    parameter int LEAD  = 4,
    parameter int TRAIL = 4,
    parameter int GAP   = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_vc,
    input  logic [5:0]  cmd_dt,
    input  logic [15:0] cmd_wc,
    input  logic [31:0] pl_data,
    input  logic        pl_valid,
    output logic        pl_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic [2:0]  out_nbytes,
    output logic        hs_active,
    output logic        err_underrun
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LEAD    = 3'd1;
    localparam logic [2:0] S_HEADER  = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_CRC     = 3'd4;
    localparam logic [2:0] S_TRAIL   = 3'd5;
    localparam logic [2:0] S_GAP     = 3'd6;

    // Hamming parity masks over header bits D[23:0] for ECC bits P0..P5
    localparam logic [23:0] c_P0_MASK = 24'hF12CB7;
    localparam logic [23:0] c_P1_MASK = 24'hF2555B;
    localparam logic [23:0] c_P2_MASK = 24'h749A6D;
    localparam logic [23:0] c_P3_MASK = 24'hB8E38E;
    localparam logic [23:0] c_P4_MASK = 24'hDF03F0;
    localparam logic [23:0] c_P5_MASK = 24'hEFFC00;

    logic [2:0]  r_state;
    logic [15:0] r_cnt;
    logic [1:0]  r_vc;
    logic [5:0]  r_dt;
    logic [15:0] r_wc;
    logic [13:0] r_words_left;
    logic [15:0] r_crc;
    logic [31:0] r_out_data;
    logic        r_out_valid;
    logic        r_out_last;
    logic [2:0]  r_out_nbytes;
    logic        r_hs;
    logic        r_err;

    logic        w_free;
    logic        w_short;
    logic [7:0]  w_ecc;
    logic [23:0] w_hdr;

    function automatic logic [15:0] f_crc_word(input logic [15:0] crc_in, input logic [31:0] d);
        logic [15:0] c;
        c = crc_in;
        for (int i = 0; i < 32; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ 16'h8408;
            else             c = c >> 1;
        end
        return c;
    endfunction

    assign w_hdr   = {r_wc, r_vc, r_dt};
    assign w_ecc   = {2'b00, ^(w_hdr & c_P5_MASK), ^(w_hdr & c_P4_MASK), ^(w_hdr & c_P3_MASK),
                      ^(w_hdr & c_P2_MASK), ^(w_hdr & c_P1_MASK), ^(w_hdr & c_P0_MASK)};
    assign w_short = (r_dt < 6'h10);
    assign w_free  = !r_out_valid || out_ready;

    assign cmd_ready    = reset_n && (r_state == S_IDLE);
    assign pl_ready     = reset_n && (r_state == S_PAYLOAD) && w_free;
    assign out_data     = r_out_data;
    assign out_valid    = r_out_valid;
    assign out_last     = r_out_last;
    assign out_nbytes   = r_out_nbytes;
    assign hs_active    = r_hs;
    assign err_underrun = r_err;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 16'd0;
            r_vc         <= 2'd0;
            r_dt         <= 6'd0;
            r_wc         <= 16'd0;
            r_words_left <= 14'd0;
            r_crc        <= 16'hFFFF;
            r_out_data   <= 32'd0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_nbytes <= 3'd0;
            r_hs         <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_vc    <= cmd_vc;
                        r_dt    <= cmd_dt;
                        r_wc    <= (cmd_dt < 6'h10) ? cmd_wc : (cmd_wc & 16'hFFFC);
                        r_crc   <= 16'hFFFF;
                        r_cnt   <= 16'd0;
                        r_state <= S_LEAD;
                    end
                end
                S_LEAD: begin
                    r_hs <= 1'b1;
                    if (r_cnt == 16'(LEAD - 1)) begin
                        r_cnt   <= 16'd0;
                        r_state <= S_HEADER;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_HEADER: begin
                    if (w_free) begin
                        r_out_data   <= {w_ecc, r_wc[15:8], r_wc[7:0], r_vc, r_dt};
                        r_out_valid  <= 1'b1;
                        r_out_nbytes <= 3'd4;
                        r_out_last   <= w_short;
                        if (w_short) begin
                            r_state <= S_TRAIL;
                        end else if (r_wc[15:2] == 14'd0) begin
                            r_state <= S_CRC;
                        end else begin
                            r_words_left <= r_wc[15:2];
                            r_state      <= S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (w_free) begin
                        if (pl_valid) begin
                            r_out_data   <= pl_data;
                            r_out_valid  <= 1'b1;
                            r_out_nbytes <= 3'd4;
                            r_out_last   <= 1'b0;
                            r_crc        <= f_crc_word(r_crc, pl_data);
                            r_words_left <= r_words_left - 14'd1;
                            if (r_words_left == 14'd1) r_state <= S_CRC;
                        end else begin
                            // Starved: let the register drain and flag it, content is unaffected
                            r_out_valid <= 1'b0;
                            r_err       <= 1'b1;
                        end
                    end
                end
                S_CRC: begin
                    if (w_free) begin
                        r_out_data   <= {16'h0000, r_crc};
                        r_out_valid  <= 1'b1;
                        r_out_nbytes <= 3'd2;
                        r_out_last   <= 1'b1;
                        r_state      <= S_TRAIL;
                    end
                end
                S_TRAIL: begin
                    // Trail timing starts only once the last word has left the register
                    if (r_out_valid) begin
                        if (out_ready) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                        end
                    end else if (r_cnt == 16'(TRAIL - 1)) begin
                        r_cnt   <= 16'd0;
                        r_hs    <= 1'b0;
                        r_state <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == 16'(GAP - 1)) begin
                        r_cnt   <= 16'd0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csi_tx_packet_gen.sv
`default_nettype none
// ============================================================================
// tb_csi_tx_packet_gen : directed table-driven bench for csi_tx_packet_gen.
// Revision 1.0
// ============================================================================
module tb_csi_tx_packet_gen;

    localparam int LEAD  = 4;
    localparam int TRAIL = 4;
    localparam int GAP   = 8;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_vc = 2'd0;
    logic [5:0]  cmd_dt = 6'd0;
    logic [15:0] cmd_wc = 16'd0;
    logic [31:0] pl_data = 32'd0;
    logic        pl_valid = 1'b0;
    logic        pl_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_last;
    logic [2:0]  out_nbytes;
    logic        hs_active;
    logic        err_underrun;

    always #5 clock = ~clock;

    csi_tx_packet_gen #(.LEAD(LEAD), .TRAIL(TRAIL), .GAP(GAP)) dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_vc(cmd_vc), .cmd_dt(cmd_dt), .cmd_wc(cmd_wc),
        .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .out_nbytes(out_nbytes),
        .hs_active(hs_active), .err_underrun(err_underrun)
    );

    typedef struct {
        logic [1:0]  vc;
        logic [5:0]  dt;
        logic [15:0] wc;
        logic [31:0] hdr;
        logic [15:0] crc;
        bit          bp;
        bit          ur;
        bit          err;
    } vec_t;

    vec_t        tbl [9];
    logic [31:0] payload [6];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] got_d [$];
    logic [2:0]  got_n [$];
    logic        got_l [$];
    int          hs_cnt, pl_rdy_cnt, gap_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_pkt(input vec_t v, input int abort_at);
        int          pidx, ur_left, nw;
        bit          cmd_done, last_seen, stall, done;
        logic [31:0] st_d;
        logic        st_l;
        nw = (v.dt >= 6'h10) ? int'(v.wc[15:2]) : 0;
        got_d.delete(); got_n.delete(); got_l.delete();
        hs_cnt = 0; pl_rdy_cnt = 0; gap_cnt = 0;
        pidx = 0; ur_left = 3; cmd_done = 0; last_seen = 0; stall = 0; done = 0;
        st_d = 32'd0; st_l = 1'b0;
        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            @(negedge clock);
            out_ready = v.bp ? cyc[0] : 1'b1;
            cmd_valid = !cmd_done;
            cmd_vc = v.vc; cmd_dt = v.dt; cmd_wc = v.wc;
            if (v.ur && pidx == 2 && ur_left > 0) begin
                pl_valid = 1'b0;
                ur_left--;
            end else begin
                pl_valid = 1'b1;
            end
            pl_data = (pidx < nw) ? payload[pidx] : 32'hDEADBEEF;
            if (abort_at >= 0 && pidx == abort_at) begin
                reset_n = 1'b0;
                done = 1;
            end else begin
                #1;
                if (hs_active) hs_cnt++;
                if (pl_ready) pl_rdy_cnt++;
                if (stall) begin
                    check("hold_data", out_data, st_d);
                    check("hold_last", {31'd0, out_last}, {31'd0, st_l});
                end
                stall = out_valid && !out_ready;
                st_d = out_data; st_l = out_last;
                if (out_valid && out_ready) begin
                    got_d.push_back(out_data);
                    got_n.push_back(out_nbytes);
                    got_l.push_back(out_last);
                    if (out_last) last_seen = 1;
                end
                if (pl_valid && pl_ready) pidx++;
                if (cmd_valid && cmd_ready) cmd_done = 1;
                if (last_seen && !hs_active) done = 1;
            end
        end
        if (!done) begin
            n_chk++; n_fail++;
            $display("FAIL packet_timeout: got no completed packet, required out_last and hs_active fall");
        end
        cmd_valid = 1'b0; pl_valid = 1'b0; out_ready = 1'b1;
        if (abort_at < 0) begin
            while (!cmd_ready && gap_cnt < 100) begin
                gap_cnt++;
                @(negedge clock); #1;
            end
        end
    endtask

    task automatic check_pkt(input vec_t v, input string tag);
        int          nw, exp_n;
        bit          long_pkt;
        logic [31:0] e_d;
        logic [2:0]  e_n;
        logic        e_l;
        long_pkt = (v.dt >= 6'h10);
        nw = long_pkt ? int'(v.wc[15:2]) : 0;
        exp_n = long_pkt ? nw + 2 : 1;
        check($sformatf("%s_nwords", tag), 32'(got_d.size()), 32'(exp_n));
        for (int i = 0; i < exp_n && i < got_d.size(); i++) begin
            if (i == 0)               begin e_d = v.hdr;             e_n = 3'd4; e_l = !long_pkt; end
            else if (i <= nw)         begin e_d = payload[i-1];      e_n = 3'd4; e_l = 1'b0;      end
            else                      begin e_d = {16'h0000, v.crc}; e_n = 3'd2; e_l = 1'b1;      end
            check($sformatf("%s_w%0d_data", tag, i), got_d[i], e_d);
            check($sformatf("%s_w%0d_nbytes", tag, i), {29'd0, got_n[i]}, {29'd0, e_n});
            check($sformatf("%s_w%0d_last", tag, i), {31'd0, got_l[i]}, {31'd0, e_l});
        end
    endtask

    initial begin
        payload[0] = 32'h020000FF; payload[1] = 32'h72F3DCB9; payload[2] = 32'h5AB8D4BB;
        payload[3] = 32'h7CC275C8; payload[4] = 32'hDF05F881; payload[5] = 32'h010000FF;
        //         vc     dt     wc        header         crc      bp ur err
        tbl[0] = '{2'd0, 6'h01, 16'h0000, 32'h07000001, 16'h0000, 0, 0, 0};  // frame end
        tbl[1] = '{2'd0, 6'h00, 16'h0000, 32'h00000000, 16'h0000, 0, 0, 0};  // frame start
        tbl[2] = '{2'd1, 6'h00, 16'h0000, 32'h16000040, 16'h0000, 0, 0, 0};  // VC1 frame start
        tbl[3] = '{2'd0, 6'h02, 16'h0001, 32'h11000102, 16'h0000, 0, 0, 0};  // line start 1
        tbl[4] = '{2'd0, 6'h2A, 16'h0000, 32'h1000002A, 16'hFFFF, 0, 0, 0};  // empty long
        tbl[5] = '{2'd0, 6'h2A, 16'h0018, 32'h1300182A, 16'h00F0, 0, 0, 0};  // CRC vector
        tbl[6] = '{2'd0, 6'h2A, 16'h001B, 32'h1300182A, 16'h00F0, 0, 0, 0};  // WC[1:0] dropped
        tbl[7] = '{2'd0, 6'h2A, 16'h0018, 32'h1300182A, 16'h00F0, 1, 0, 0};  // backpressure
        tbl[8] = '{2'd0, 6'h2A, 16'h0018, 32'h1300182A, 16'h00F0, 0, 1, 1};  // underrun

        repeat (3) @(negedge clock);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_hs_active", {31'd0, hs_active}, 32'd0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_pl_ready", {31'd0, pl_ready}, 32'd0);
        check("rst_err", {31'd0, err_underrun}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_nbytes", {29'd0, out_nbytes}, 32'd0);
        reset_n = 1'b1;
        @(negedge clock); #1;
        check("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        for (int i = 0; i < 9; i++) begin
            run_pkt(tbl[i], -1);
            check_pkt(tbl[i], $sformatf("pkt%0d", i));
            if (!tbl[i].bp && !tbl[i].ur)
                check($sformatf("pkt%0d_hs_cycles", i), 32'(hs_cnt),
                      32'(LEAD + TRAIL + 1 + ((tbl[i].dt >= 6'h10) ? int'(tbl[i].wc[15:2]) + 1 : 0)));
            if (tbl[i].dt < 6'h10)
                check($sformatf("pkt%0d_no_pl_ready", i), 32'(pl_rdy_cnt), 32'd0);
            check($sformatf("pkt%0d_gap", i), 32'(gap_cnt), 32'(GAP));
            check($sformatf("pkt%0d_err", i), {31'd0, err_underrun}, {31'd0, tbl[i].err});
        end

        // err_underrun stays set across a clean packet
        run_pkt(tbl[0], -1);
        check_pkt(tbl[0], "sticky_fe");
        check("sticky_err", {31'd0, err_underrun}, 32'd1);

        // Reset during PAYLOAD abandons the packet
        run_pkt(tbl[5], 3);
        @(negedge clock); #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_out_last", {31'd0, out_last}, 32'd0);
        check("mid_rst_hs_active", {31'd0, hs_active}, 32'd0);
        check("mid_rst_pl_ready", {31'd0, pl_ready}, 32'd0);
        check("mid_rst_err", {31'd0, err_underrun}, 32'd0);
        check("mid_rst_out_data", out_data, 32'd0);
        check("mid_rst_out_nbytes", {29'd0, out_nbytes}, 32'd0);
        check("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        reset_n = 1'b1;
        @(negedge clock); #1;
        check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        run_pkt(tbl[0], -1);
        check_pkt(tbl[0], "post_rst_fe");
        check("post_rst_hs_cycles", 32'(hs_cnt), 32'(LEAD + TRAIL + 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
